// File: rtl/serv_dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : serv_dmem_responder_if
// Description : Wishbone-classic data-bus bundle between core and data memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface serv_dmem_responder_if;
    logic [31:0] i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
        input  o_wb_rdt, o_wb_ack
    );

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
        output o_wb_rdt, o_wb_ack
    );
endinterface
`default_nettype wire

// File: rtl/serv_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : serv_dmem_responder
// Description : Data-bus memory responder with byte-lane RAM and wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module serv_dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int AW          = $clog2(DEPTH),
    parameter int WAIT_STATES = 0
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    serv_dmem_responder_if.slave  bus,
    output logic                  o_busy
);

    localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [AW-1:0]   r_adr;
    logic [31:0]     r_dat;
    logic [3:0]      r_sel;
    logic            r_we;
    logic [31:0]     r_rdt;
    logic            r_ack;
    logic            r_busy;
    logic [31:0]     r_mem [DEPTH];

    logic            w_idle;
    logic            w_enter_ack;
    logic [AW-1:0]   w_adr;
    logic [31:0]     w_dat;
    logic [3:0]      w_sel;
    logic            w_we;

    // With zero wait states the access completes straight from IDLE, so the
    // live bus fields are used instead of the (not yet loaded) latched copy.
    assign w_idle      = (r_state == S_IDLE);
    assign w_adr       = w_idle ? bus.i_wb_adr[AW+1:2] : r_adr;
    assign w_dat       = w_idle ? bus.i_wb_dat         : r_dat;
    assign w_sel       = w_idle ? bus.i_wb_sel         : r_sel;
    assign w_we        = w_idle ? bus.i_wb_we          : r_we;
    assign w_enter_ack = i_rst_n && bus.i_wb_cyc &&
                         ((w_idle && (c_WAIT_INIT == 4'd0)) ||
                          ((r_state == S_WAIT) && (r_cnt == 4'd1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_adr   <= '0;
            r_dat   <= 32'd0;
            r_sel   <= 4'd0;
            r_we    <= 1'b0;
            r_rdt   <= 32'd0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_wb_cyc) begin
                        r_adr <= bus.i_wb_adr[AW+1:2];
                        r_dat <= bus.i_wb_dat;
                        r_sel <= bus.i_wb_sel;
                        r_we  <= bus.i_wb_we;
                        if (c_WAIT_INIT == 4'd0) begin
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= c_WAIT_INIT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.i_wb_cyc) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == 4'd1) begin
                        r_state <= S_ACK;
                        r_cnt   <= 4'd0;
                        r_ack   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_enter_ack && !w_we) begin
                r_rdt <= r_mem[w_adr];
            end
        end
    end

    // RAM contents deliberately survive reset; only the commit is gated.
    always_ff @(posedge i_clk) begin
        if (w_enter_ack && w_we) begin
            for (int n = 0; n < 4; n++) begin
                if (w_sel[n]) begin
                    r_mem[w_adr][8*n +: 8] <= w_dat[8*n +: 8];
                end
            end
        end
    end

    assign bus.o_wb_rdt = r_rdt;
    assign bus.o_wb_ack = r_ack;
    assign o_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_serv_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serv_dmem_responder
// Description : Scoreboard bench over three responders (0, 2, 3 wait states).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serv_dmem_responder;

    typedef struct {
        int          d;
        bit          we;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic [31:0] adr   [3];
    logic [31:0] dat   [3];
    logic [3:0]  sel   [3];
    logic        we    [3];
    logic        cyc   [3];
    logic [31:0] rdt   [3];
    logic        ack   [3];
    logic        busy  [3];

    int          w_st [3] = '{0, 2, 3};
    logic [31:0] model   [3][256];
    logic [31:0] last_rd [3];
    exp_t        sb [$];
    exp_t        mon_e;
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk = ~clk;

    serv_dmem_responder_if if_0 ();
    serv_dmem_responder_if if_1 ();
    serv_dmem_responder_if if_2 ();

    assign if_0.i_wb_adr = adr[0];
    assign if_0.i_wb_dat = dat[0];
    assign if_0.i_wb_sel = sel[0];
    assign if_0.i_wb_we  = we[0];
    assign if_0.i_wb_cyc = cyc[0];
    assign rdt[0]        = if_0.o_wb_rdt;
    assign ack[0]        = if_0.o_wb_ack;
    assign if_1.i_wb_adr = adr[1];
    assign if_1.i_wb_dat = dat[1];
    assign if_1.i_wb_sel = sel[1];
    assign if_1.i_wb_we  = we[1];
    assign if_1.i_wb_cyc = cyc[1];
    assign rdt[1]        = if_1.o_wb_rdt;
    assign ack[1]        = if_1.o_wb_ack;
    assign if_2.i_wb_adr = adr[2];
    assign if_2.i_wb_dat = dat[2];
    assign if_2.i_wb_sel = sel[2];
    assign if_2.i_wb_we  = we[2];
    assign if_2.i_wb_cyc = cyc[2];
    assign rdt[2]        = if_2.o_wb_rdt;
    assign ack[2]        = if_2.o_wb_ack;

    serv_dmem_responder #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .bus(if_0.slave), .o_busy(busy[0]));
    serv_dmem_responder #(.DEPTH(256), .WAIT_STATES(2)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .bus(if_1.slave), .o_busy(busy[1]));
    serv_dmem_responder #(.DEPTH(256), .WAIT_STATES(3)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n[2]), .bus(if_2.slave), .o_busy(busy[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // One complete bus access; the expected outcome goes to the scoreboard.
    task automatic access(input int d, input bit w, input logic [31:0] a,
                          input logic [31:0] dt, input logic [3:0] s,
                          output logic [31:0] rd);
        exp_t e;
        int   lat;
        @(negedge clk);
        adr[d] = a; dat[d] = dt; sel[d] = s; we[d] = w; cyc[d] = 1'b1;
        e.d = d; e.we = w; e.exp = model[d][a[9:2]];
        if (w) begin
            for (int n = 0; n < 4; n++)
                if (s[n]) model[d][a[9:2]][8*n +: 8] = dt[8*n +: 8];
        end
        sb.push_back(e);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ack[d]) begin
                lat = k;
                break;
            end
            if (k <= w_st[d]) chk("busy_wait", 32'(busy[d]), 32'd1);
        end
        chk("latency", lat, 1 + w_st[d]);
        chk("busy_at_ack", 32'(busy[d]), 32'd0);
        rd = rdt[d];
        @(negedge clk);
        cyc[d] = 1'b0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ack[d] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_ack", 32'(ack[d]), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_dut", d, mon_e.d);
                    if (!mon_e.we) begin
                        chk("rdt", rdt[d], mon_e.exp);
                        last_rd[d] = mon_e.exp;
                    end else begin
                        chk("rdt_hold_wr", rdt[d], last_rd[d]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        exp_t        e;
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; adr[d] = 32'd0; dat[d] = 32'd0; sel[d] = 4'd0;
            we[d] = 1'b0; cyc[d] = 1'b0; last_rd[d] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_ack",  32'(ack[d]),  32'd0);
            chk("rst_busy", 32'(busy[d]), 32'd0);
            chk("rst_rdt",  rdt[d],       32'd0);
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

        // Full word, zero wait states
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
        access(0, 1'b0, 32'h10, 32'h0, 4'hF, rd);
        chk("full_word", rd, 32'hDEADBEEF);

        // Byte lanes and empty select
        access(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd);
        access(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0010, rd);
        access(0, 1'b0, 32'h20, 32'h0, 4'h0, rd);
        chk("byte_lane", rd, 32'h1122CC44);
        access(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd);
        access(0, 1'b0, 32'h20, 32'h0, 4'hF, rd);
        chk("sel_zero", rd, 32'h1122CC44);
        access(0, 1'b1, 32'h24, 32'h0F0F0F0F, 4'b1001, rd);
        access(0, 1'b0, 32'h24, 32'h0, 4'hF, rd);

        // Aliasing modulo 4*DEPTH
        access(0, 1'b1, 32'h0000_0404, 32'hCAFEF00D, 4'hF, rd);
        access(0, 1'b0, 32'h0000_0004, 32'h0, 4'hF, rd);
        chk("alias_4", rd, 32'hCAFEF00D);
        access(0, 1'b0, 32'h0000_0006, 32'h0, 4'hF, rd);
        chk("alias_6", rd, 32'hCAFEF00D);

        // Two wait states, single access then cyc held through the ack
        access(1, 1'b1, 32'h40, 32'h0BADF00D, 4'hF, rd);
        access(1, 1'b0, 32'h40, 32'h0, 4'hF, rd);
        chk("ws2_read", rd, 32'h0BADF00D);
        @(negedge clk);
        adr[1] = 32'h40; we[1] = 1'b0; sel[1] = 4'hF; cyc[1] = 1'b1;
        e.d = 1; e.we = 1'b0; e.exp = model[1][8'h10];
        sb.push_back(e);
        sb.push_back(e);
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            chk($sformatf("hold_ack_c%0d", c), 32'(ack[1]), 32'((c == 3) || (c == 7)));
        end
        @(negedge clk);
        cyc[1] = 1'b0;
        repeat (2) @(negedge clk);

        // Abort with three wait states
        access(2, 1'b1, 32'h30, 32'h55667788, 4'hF, rd);
        access(2, 1'b0, 32'h30, 32'h0, 4'hF, rd);
        @(negedge clk);
        adr[2] = 32'h30; dat[2] = 32'h0; sel[2] = 4'hF; we[2] = 1'b1; cyc[2] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cyc[2] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("abort_noack", 32'(ack[2]), 32'd0);
        end
        chk("abort_busy", 32'(busy[2]), 32'd0);
        chk("abort_rdt", rdt[2], 32'h55667788);
        access(2, 1'b0, 32'h30, 32'h0, 4'hF, rd);
        chk("abort_mem", rd, 32'h55667788);

        // Asynchronous reset in the middle of a write
        @(negedge clk);
        adr[1] = 32'h40; dat[1] = 32'h12345678; sel[1] = 4'hF; we[1] = 1'b1; cyc[1] = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(busy[1]), 32'd1);
        #1 rst_n[1] = 1'b0;
        #1;
        chk("rst_mid_ack",  32'(ack[1]),  32'd0);
        chk("rst_mid_busy", 32'(busy[1]), 32'd0);
        chk("rst_mid_rdt",  rdt[1],       32'd0);
        @(negedge clk);
        cyc[1] = 1'b0;
        last_rd[1] = 32'd0;
        @(negedge clk);
        rst_n[1] = 1'b1;
        access(1, 1'b0, 32'h40, 32'h0, 4'hF, rd);
        chk("rst_no_commit", rd, 32'h0BADF00D);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
